// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encoding and run-counter helpers shared by cpu_sequencer.
package cpu_seq_pkg;

  localparam int W_CYC = 16;

  typedef enum logic [3:0] {
    S_HDR_I   = 4'd0,
    S_LOAD_I  = 4'd1,
    S_HDR_D   = 4'd2,
    S_LOAD_D  = 4'd3,
    S_HDR_OB  = 4'd4,
    S_HDR_OL  = 4'd5,
    S_START   = 4'd6,
    S_RUN     = 4'd7,
    S_DUMP_RD = 4'd8,
    S_DUMP_TX = 4'd9,
    S_TRL_LO  = 4'd10,
    S_TRL_HI  = 4'd11
  } state_t;

  // Saturating increment: the run counter sticks at all-ones instead of wrapping.
  function automatic logic [W_CYC-1:0] sat_inc(input logic [W_CYC-1:0] v);
    if (v == {W_CYC{1'b1}}) begin
      return v;
    end else begin
      return v + {{(W_CYC-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: loads a program and operands from a host byte stream, runs
// the cpu once, then returns a DRAM window plus the run-cycle count.
module cpu_sequencer #(
  parameter int W_ADDR = 8,
  parameter int W_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              cpu_start,
  input  logic              cpu_idle,
  input  logic [W_ADDR-1:0] cpu_iram_addr,
  input  logic              cpu_iram_write,
  output logic [15:0]       cpu_iram_dout,
  input  logic [W_ADDR-1:0] cpu_dram_addr,
  input  logic [7:0]        cpu_dram_din,
  input  logic              cpu_dram_write,
  output logic [7:0]        cpu_dram_dout,
  output logic [W_ADDR-1:0] iram_addr,
  output logic [15:0]       iram_din,
  output logic              iram_write,
  input  logic [15:0]       iram_dout,
  output logic [W_ADDR-1:0] dram_addr,
  output logic [7:0]        dram_din,
  output logic              dram_write,
  input  logic [7:0]        dram_dout,
  output logic              busy
);
  import cpu_seq_pkg::*;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s_ready;
  logic                r_busy;
  logic                r_cpu_start;
  logic [7:0]          r_cnt;
  logic                r_odd;
  logic [7:0]          r_opc;
  logic [7:0]          r_n_i;
  logic [7:0]          r_n_d;
  logic [7:0]          r_o_base;
  logic [7:0]          r_o_len;
  logic [W_CYC-1:0]    r_cyc;
  logic                r_rd_pend;
  logic                r_m_valid;
  logic [7:0]          r_m_data;
  logic                r_iram_we;
  logic [W_ADDR-1:0]   r_iram_addr;
  logic [15:0]         r_iram_din;
  logic                r_dram_we;
  logic [W_ADDR-1:0]   r_dram_addr;
  logic [7:0]          r_dram_din;

  logic                w_s_fire;
  logic                w_m_fire;
  logic                w_last_i;
  logic                w_last_d;
  logic                w_last_o;
  logic                w_cpu_own;
  logic [W_CYC-1:0]    w_cyc_inc;
  logic [W_ADDR-1:0]   w_seq_dram_addr;

  assign w_s_fire  = s_valid && r_s_ready;
  assign w_m_fire  = r_m_valid && m_ready;
  assign w_last_i  = (r_cnt == (r_n_i - 8'd1));
  assign w_last_d  = (r_cnt == (r_n_d - 8'd1));
  assign w_last_o  = (r_cnt == (r_o_len - 8'd1));
  assign w_cyc_inc = sat_inc(r_cyc);
  // The cpu owns both RAMs only while it is being started or is running.
  assign w_cpu_own = (r_state == S_START) || (r_state == S_RUN);

  // Dump reads walk the window from o_base and wrap at the top of DRAM.
  assign w_seq_dram_addr = (r_state == S_DUMP_RD) ?
                           (W_ADDR'(r_o_base) + W_ADDR'(r_cnt)) : r_dram_addr;

  assign iram_addr  = w_cpu_own ? cpu_iram_addr  : r_iram_addr;
  assign iram_din   = r_iram_din;
  assign iram_write = w_cpu_own ? cpu_iram_write : r_iram_we;
  assign dram_addr  = w_cpu_own ? cpu_dram_addr  : w_seq_dram_addr;
  assign dram_din   = w_cpu_own ? cpu_dram_din   : r_dram_din;
  assign dram_write = w_cpu_own ? cpu_dram_write : r_dram_we;

  assign cpu_iram_dout = iram_dout;
  assign cpu_dram_dout = dram_dout;

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign cpu_start = r_cpu_start;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;

  // Next-state decode; the state only moves on a handshake or a cpu/read event.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR_I: begin
        if (w_s_fire) w_state_nxt = (s_data == 8'd0) ? S_HDR_D : S_LOAD_I;
        else          w_state_nxt = r_state;
      end
      S_LOAD_I: begin
        if (w_s_fire && r_odd && w_last_i) w_state_nxt = S_HDR_D;
        else                               w_state_nxt = r_state;
      end
      S_HDR_D: begin
        if (w_s_fire) w_state_nxt = (s_data == 8'd0) ? S_HDR_OB : S_LOAD_D;
        else          w_state_nxt = r_state;
      end
      S_LOAD_D: begin
        if (w_s_fire && w_last_d) w_state_nxt = S_HDR_OB;
        else                      w_state_nxt = r_state;
      end
      S_HDR_OB: begin
        if (w_s_fire) w_state_nxt = S_HDR_OL;
        else          w_state_nxt = r_state;
      end
      S_HDR_OL: begin
        if (w_s_fire) w_state_nxt = S_START;
        else          w_state_nxt = r_state;
      end
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        // r_cyc is still zero on the first run cycle, so idle is ignored there.
        if ((r_cyc != '0) && cpu_idle) w_state_nxt = (r_o_len == 8'd0) ? S_TRL_LO : S_DUMP_RD;
        else                           w_state_nxt = r_state;
      end
      S_DUMP_RD: begin
        if (r_rd_pend) w_state_nxt = S_DUMP_TX;
        else           w_state_nxt = r_state;
      end
      S_DUMP_TX: begin
        if (w_m_fire) w_state_nxt = w_last_o ? S_TRL_LO : S_DUMP_RD;
        else          w_state_nxt = r_state;
      end
      S_TRL_LO: begin
        if (w_m_fire) w_state_nxt = S_TRL_HI;
        else          w_state_nxt = r_state;
      end
      S_TRL_HI: begin
        if (w_m_fire) w_state_nxt = S_HDR_I;
        else          w_state_nxt = r_state;
      end
      default: w_state_nxt = S_HDR_I;
    endcase
  end

  // State register plus flags decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HDR_I;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_cpu_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_ready   <= w_state_nxt inside {S_HDR_I, S_LOAD_I, S_HDR_D, S_LOAD_D, S_HDR_OB, S_HDR_OL};
      r_busy      <= (w_state_nxt != S_HDR_I);
      r_cpu_start <= (w_state_nxt == S_START);
    end
  end

  // Datapath: header latches, load counter, RAM write pipeline, cycle counter, result byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_odd       <= 1'b0;
      r_opc       <= 8'd0;
      r_n_i       <= 8'd0;
      r_n_d       <= 8'd0;
      r_o_base    <= 8'd0;
      r_o_len     <= 8'd0;
      r_cyc       <= '0;
      r_rd_pend   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= 8'd0;
      r_iram_we   <= 1'b0;
      r_iram_addr <= '0;
      r_iram_din  <= 16'd0;
      r_dram_we   <= 1'b0;
      r_dram_addr <= '0;
      r_dram_din  <= 8'd0;
    end else begin
      r_iram_we <= 1'b0;
      r_dram_we <= 1'b0;
      r_rd_pend <= 1'b0;
      case (r_state)
        S_HDR_I: if (w_s_fire) begin
          r_n_i <= s_data;
          r_cnt <= 8'd0;
          r_odd <= 1'b0;
        end
        S_LOAD_I: if (w_s_fire) begin
          if (!r_odd) begin
            r_opc <= s_data;
            r_odd <= 1'b1;
          end else begin
            r_odd       <= 1'b0;
            r_iram_we   <= 1'b1;
            r_iram_addr <= W_ADDR'(r_cnt);
            r_iram_din  <= {s_data, r_opc};
            r_cnt       <= r_cnt + 8'd1;
          end
        end
        S_HDR_D: if (w_s_fire) begin
          r_n_d <= s_data;
          r_cnt <= 8'd0;
        end
        S_LOAD_D: if (w_s_fire) begin
          r_dram_we   <= 1'b1;
          r_dram_addr <= W_ADDR'(r_cnt);
          r_dram_din  <= s_data;
          r_cnt       <= r_cnt + 8'd1;
        end
        S_HDR_OB: if (w_s_fire) r_o_base <= s_data;
        S_HDR_OL: if (w_s_fire) r_o_len <= s_data;
        S_START: begin
          r_cyc <= '0;
          r_cnt <= 8'd0;
        end
        S_RUN: begin
          r_cyc <= w_cyc_inc;
          // Going straight to the trailer must carry this cycle's increment too.
          if (w_state_nxt == S_TRL_LO) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_cyc_inc[7:0];
          end
        end
        S_DUMP_RD: begin
          // First cycle presents the address; second cycle sees the synchronous read data.
          if (!r_rd_pend) begin
            r_rd_pend <= 1'b1;
          end else begin
            r_m_valid <= 1'b1;
            r_m_data  <= dram_dout;
          end
        end
        S_DUMP_TX: if (w_m_fire) begin
          if (w_last_o) begin
            r_m_data <= r_cyc[7:0];
          end else begin
            r_m_valid <= 1'b0;
            r_cnt     <= r_cnt + 8'd1;
          end
        end
        S_TRL_LO: if (w_m_fire) r_m_data <= r_cyc[15:8];
        S_TRL_HI: if (w_m_fire) r_m_valid <= 1'b0;
        default: begin
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed frames against behavioural IRAM/DRAM models and a scripted cpu.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        cpu_start;
  logic        cpu_idle;
  logic [7:0]  cpu_iram_addr;
  logic        cpu_iram_write;
  logic [15:0] cpu_iram_dout;
  logic [7:0]  cpu_dram_addr;
  logic [7:0]  cpu_dram_din;
  logic        cpu_dram_write;
  logic [7:0]  cpu_dram_dout;
  logic [7:0]  iram_addr;
  logic [15:0] iram_din;
  logic        iram_write;
  logic [15:0] iram_dout;
  logic [7:0]  dram_addr;
  logic [7:0]  dram_din;
  logic        dram_write;
  logic [7:0]  dram_dout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] iram_m [256];
  logic [7:0]  dram_m [256];
  logic        mem_init;

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  wr_t ilog [$];

  always #5 clk = ~clk;

  cpu_sequencer #(.W_ADDR(8), .W_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle),
    .cpu_iram_addr(cpu_iram_addr), .cpu_iram_write(cpu_iram_write), .cpu_iram_dout(cpu_iram_dout),
    .cpu_dram_addr(cpu_dram_addr), .cpu_dram_din(cpu_dram_din), .cpu_dram_write(cpu_dram_write),
    .cpu_dram_dout(cpu_dram_dout),
    .iram_addr(iram_addr), .iram_din(iram_din), .iram_write(iram_write), .iram_dout(iram_dout),
    .dram_addr(dram_addr), .dram_din(dram_din), .dram_write(dram_write), .dram_dout(dram_dout),
    .busy(busy)
  );

  // Synchronous-read RAM models; DRAM starts as addr ^ 8'h3C, and IRAM writes are logged.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        dram_m[i] <= 8'(i) ^ 8'h3C;
        iram_m[i] <= 16'h0000;
      end
    end else begin
      if (iram_write) begin
        iram_m[iram_addr] <= iram_din;
        ilog.push_back('{iram_addr, iram_din});
      end
      if (dram_write) dram_m[dram_addr] <= dram_din;
    end
    iram_dout <= iram_m[iram_addr];
    dram_dout <= dram_m[dram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_wait", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic recv(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {23'd0, m_valid, m_data}, {23'd0, 1'b1, exp});
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  // Scripted cpu: busy for m run cycles, optionally storing 8'h5A at 8'h10 on run cycle 3.
  task automatic run_cpu(input int m, input bit store);
    int n;
    n = 0;
    while (!cpu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cpu_start_seen", {31'd0, cpu_start}, 32'd1);
    cpu_idle = 1'b0;
    @(negedge clk);
    check("cpu_start_one_cycle", {31'd0, cpu_start}, 32'd0);
    for (int i = 1; i <= m; i++) begin
      if (store && i == 3) begin
        cpu_dram_addr  = 8'h10;
        cpu_dram_din   = 8'h5A;
        cpu_dram_write = 1'b1;
        #1;
        check("run_dram_write_passthru", {31'd0, dram_write}, 32'd1);
        check("run_dram_addr_passthru", {24'd0, dram_addr}, 32'h10);
      end
      if (store && i == 4) cpu_dram_write = 1'b0;
      if (i == m) cpu_idle = 1'b1;
      if (i < m) @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
    cpu_idle = 1'b1;
    cpu_iram_addr = 8'd0; cpu_iram_write = 1'b0;
    cpu_dram_addr = 8'd0; cpu_dram_din = 8'd0; cpu_dram_write = 1'b0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;

    // Reset state
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    check("rst_iram_write", {31'd0, iram_write}, 32'd0);
    check("rst_dram_write", {31'd0, dram_write}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", {31'd0, s_ready}, 32'd1);

    // Frame 1: two program words, no data, empty window, cpu idle immediately.
    send(8'h02); send(8'h06); send(8'h05); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00); send(8'h00);
    s_valid = 1'b0;
    check("f1_busy", {31'd0, busy}, 32'd1);
    run_cpu(1, 1'b0);
    recv("f1_cnt_lo", 8'h02);
    recv("f1_cnt_hi", 8'h00);
    @(negedge clk);
    check("f1_back_to_hdr_busy", {31'd0, busy}, 32'd0);
    check("f1_iram_writes", ilog.size(), 32'd2);
    if (ilog.size() >= 2) begin
      check("f1_w0", {8'd0, ilog[0].a, ilog[0].d}, {8'd0, 8'h00, 16'h0506});
      check("f1_w1", {8'd0, ilog[1].a, ilog[1].d}, {8'd0, 8'h01, 16'h0000});
    end

    // Frame 2: three data bytes with a blocked cpu store, wrapping dump, backpressure.
    send(8'h00); send(8'h03);
    cpu_dram_addr = 8'h40; cpu_dram_din = 8'hEE; cpu_dram_write = 1'b1;
    send(8'hAA); send(8'hBB); send(8'hCC);
    cpu_dram_write = 1'b0;
    send(8'hFE); send(8'h04);
    s_valid = 1'b0;
    check("f2_dram0", {24'd0, dram_m[0]}, 32'hAA);
    check("f2_dram1", {24'd0, dram_m[1]}, 32'hBB);
    check("f2_dram2", {24'd0, dram_m[2]}, 32'hCC);
    check("f2_cpu_write_blocked", {24'd0, dram_m[8'h40]}, 32'h7C);
    run_cpu(5, 1'b1);
    recv("f2_dump_fe", 8'hC2);
    recv("f2_dump_ff", 8'hC3);
    for (int n = 0; n < 200 && !m_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("f2_hold_valid", {31'd0, m_valid}, 32'd1);
      check("f2_hold_data", {24'd0, m_data}, 32'hAA);
    end
    recv("f2_dump_00", 8'hAA);
    recv("f2_dump_01", 8'hBB);
    recv("f2_cnt_lo", 8'h05);
    recv("f2_cnt_hi", 8'h00);
    check("f2_cpu_store", {24'd0, dram_m[8'h10]}, 32'h5A);

    // Frame 3: reset in the middle of the program load.
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_iram_write", {31'd0, iram_write}, 32'd0);
    check("mid_rst_dram_write", {31'd0, dram_write}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("mid_rst_busy_after", {31'd0, busy}, 32'd0);
    check("mid_rst_iram_writes", ilog.size(), 32'd3);
    if (ilog.size() >= 3) check("mid_rst_w0", {8'd0, ilog[2].a, ilog[2].d}, {8'd0, 8'h00, 16'h2211});

    // Frame 4: long run saturates the counter; one-byte dump of the cpu-stored byte.
    send(8'h00); send(8'h00); send(8'h10); send(8'h01);
    s_valid = 1'b0;
    run_cpu(65540, 1'b0);
    recv("f4_dump_10", 8'h5A);
    recv("f4_cnt_lo_sat", 8'hFF);
    recv("f4_cnt_hi_sat", 8'hFF);
    @(negedge clk);
    check("f4_end_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
